// File: rtl/mag_sched_if.sv
// Bus bundle for mag_sched: requester quads, pipeline issue/return, result stream.
// The slave modport is the scheduler's view; master is the surrounding logic's view.
`timescale 1ns/1ps
interface mag_sched_if #(
    parameter int PIX_W  = 8,
    parameter int MAG_W  = 13,
    parameter int TAN_W  = 12,
    parameter int FIFO_D = 32
);
    localparam int CW = $clog2(FIFO_D) + 1;

    // valid/ready: a transfer happens on a rising clk edge where both valid and
    // ready are high; valid never waits on ready, and ready may depend on valid.
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [4*PIX_W-1:0] req_pixel0;
    logic [4*PIX_W-1:0] req_pixel1;

    logic               pipe_ivalid;
    logic [4*PIX_W-1:0] pipe_pixel;
    logic               pipe_ovalid;
    logic [MAG_W-1:0]   pipe_mag;
    logic [TAN_W-1:0]   pipe_tan;

    logic               out_valid;
    logic               out_ready;
    logic [MAG_W-1:0]   out_mag;
    logic [TAN_W-1:0]   out_tan;
    logic               out_id;
    logic               err_sync;

    // Credit state made visible for checkers.
    logic [CW-1:0]      dbg_inflight;
    logic [CW-1:0]      dbg_cnt;

    modport slave (
        input  req_valid, req_pixel0, req_pixel1,
        input  pipe_ovalid, pipe_mag, pipe_tan,
        input  out_ready,
        output req_ready, pipe_ivalid, pipe_pixel,
        output out_valid, out_mag, out_tan, out_id, err_sync,
        output dbg_inflight, dbg_cnt
    );

    modport master (
        output req_valid, req_pixel0, req_pixel1,
        output pipe_ovalid, pipe_mag, pipe_tan,
        output out_ready,
        input  req_ready, pipe_ivalid, pipe_pixel,
        input  out_valid, out_mag, out_tan, out_id, err_sync,
        input  dbg_inflight, dbg_cnt
    );
endinterface

// File: rtl/mag_sched.sv
// Round-robin issue scheduler for the shared magnitude/tan pipeline, with an id
// tag delay line and a credit-protected first-word-fall-through result FIFO.
`timescale 1ns/1ps
module mag_sched #(
    parameter int PIX_W  = 8,
    parameter int MAG_W  = 13,
    parameter int TAN_W  = 12,
    parameter int LAT    = 16,
    parameter int FIFO_D = 32
) (
    input logic       clk,
    input logic       rst,
    mag_sched_if.slave bus
);
    localparam int QW = 4 * PIX_W;
    localparam int PW = $clog2(FIFO_D);
    localparam int CW = PW + 1;
    localparam int EW = 1 + MAG_W + TAN_W;

    logic          last;
    logic [1:0]    grant;
    logic          credit_ok;
    logic [CW:0]   committed;
    logic          hs;
    logic          hs_id;
    logic [CW-1:0] inflight;
    logic [CW-1:0] cnt;
    logic [LAT:0]  tag_v;
    logic [LAT:0]  tag_id;
    logic          ret_ok;
    logic          pop;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [EW-1:0] mem [FIFO_D];
    logic [EW-1:0] head;
    logic          pipe_ivalid_q;
    logic [QW-1:0] pipe_pixel_q;
    logic          err_q;

    // Contention goes to whichever requester was not served last.
    always_comb begin
        grant = 2'b00;
        if (bus.req_valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = bus.req_valid;
        end
    end

    // Every quad in the pipeline or the FIFO holds a slot, so a return can never
    // find the FIFO full.
    assign committed     = {1'b0, inflight} + {1'b0, cnt};
    assign credit_ok     = committed < (CW + 1)'(FIFO_D);
    assign bus.req_ready = rst ? (grant & {2{credit_ok}}) : 2'b00;

    assign hs     = |(bus.req_valid & bus.req_ready);
    assign hs_id  = bus.req_ready[1];
    assign ret_ok = bus.pipe_ovalid & (inflight != '0);
    assign pop    = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            last <= 1'b1;
        end else if (hs) begin
            last <= hs_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_ivalid_q <= 1'b0;
            pipe_pixel_q  <= '0;
        end else begin
            pipe_ivalid_q <= hs;
            if (hs) begin
                pipe_pixel_q <= hs_id ? bus.req_pixel1 : bus.req_pixel0;
            end
        end
    end

    assign bus.pipe_ivalid = pipe_ivalid_q;
    assign bus.pipe_pixel  = pipe_pixel_q;

    // Slot 0 lines up with pipe_ivalid, so slot LAT lines up with pipe_ovalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= {tag_v[LAT-1:0], hs};
            tag_id <= {tag_id[LAT-1:0], hs_id};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if ((bus.pipe_ovalid && inflight == '0) ||
                     (bus.pipe_ovalid != tag_v[LAT])) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_sync = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            case ({hs, ret_ok})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            case ({ret_ok, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (ret_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && ret_ok) begin
            mem[wptr] <= {tag_id[LAT], bus.pipe_mag, bus.pipe_tan};
        end
    end

    // Storage is not reset; outputs are gated so an empty FIFO shows zeros.
    assign head          = mem[rptr];
    assign bus.out_valid = (cnt != '0);
    assign bus.out_id    = bus.out_valid & head[EW-1];
    assign bus.out_mag   = bus.out_valid ? head[EW-2:TAN_W] : '0;
    assign bus.out_tan   = bus.out_valid ? head[TAN_W-1:0] : '0;

    assign bus.dbg_inflight = inflight;
    assign bus.dbg_cnt      = cnt;
endmodule

// File: tb/tb_mag_sched.sv
// Directed and randomized bench for mag_sched with a delay-line pipeline model
// and an in-order scoreboard of expected {id, mag, tan} results.
`timescale 1ns/1ps
module tb_mag_sched;
    localparam int PIX_W  = 8;
    localparam int MAG_W  = 13;
    localparam int TAN_W  = 12;
    localparam int LAT    = 16;
    localparam int FIFO_D = 32;
    localparam int EW     = 1 + MAG_W + TAN_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mag_sched_if #(.PIX_W(PIX_W), .MAG_W(MAG_W), .TAN_W(TAN_W), .FIFO_D(FIFO_D)) bus ();

    mag_sched #(
        .PIX_W(PIX_W), .MAG_W(MAG_W), .TAN_W(TAN_W), .LAT(LAT), .FIFO_D(FIFO_D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [EW-1:0] exp_q[$];
    int            exp_rdy_q[$];
    int            outstanding;
    logic          exp_last;
    logic          prev_hs;
    logic [31:0]   prev_pix;
    logic          exp_err;
    logic          spur;
    int            obs_hs;
    int            last_hs_cyc;
    int            first_valid_cyc;
    logic [32:0]   pline [LAT+1];

    function automatic logic [MAG_W-1:0] f_mag(input logic [31:0] q);
        int t, b, l, r;
        t = int'(q[31:24]); b = int'(q[23:16]); l = int'(q[15:8]); r = int'(q[7:0]);
        return MAG_W'((t > b ? t - b : b - t) + (l > r ? l - r : r - l));
    endfunction

    function automatic logic [TAN_W-1:0] f_tan(input logic [31:0] q);
        int t, b, l, r;
        t = int'(q[31:24]); b = int'(q[23:16]); l = int'(q[15:8]); r = int'(q[7:0]);
        return TAN_W'(((t * 7 + l * 3) ^ (b << 4) ^ r) & 32'hfff);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fixed-latency pipeline: whatever is issued in cycle c returns in cycle c+LAT.
    task automatic pipe_step();
        if (!rst) begin
            for (int i = 0; i <= LAT; i++) pline[i] = '0;
        end else begin
            for (int i = LAT; i > 0; i--) pline[i] = pline[i-1];
            pline[0] = {bus.pipe_ivalid, bus.pipe_pixel};
        end
        bus.pipe_ovalid = pline[LAT][32] | spur;
        bus.pipe_mag    = f_mag(pline[LAT][31:0]);
        bus.pipe_tan    = f_tan(pline[LAT][31:0]);
    endtask

    task automatic model_step();
        logic [1:0]  g;
        logic [1:0]  exp_rdy;
        logic        ev;
        logic [31:0] q;
        if (!rst) begin
            chk("ready_in_reset", 64'(bus.req_ready), 64'(0));
            exp_q.delete();
            exp_rdy_q.delete();
            outstanding = 0;
            exp_last    = 1'b1;
            prev_hs     = 1'b0;
            prev_pix    = '0;
            exp_err     = 1'b0;
            return;
        end
        ev = (exp_q.size() > 0) && (exp_rdy_q[0] <= cyc);
        chk("out_valid", 64'(bus.out_valid), 64'(ev));
        if (ev) chk("out_data", 64'({bus.out_id, bus.out_mag, bus.out_tan}), 64'(exp_q[0]));
        chk("pipe_ivalid", 64'(bus.pipe_ivalid), 64'(prev_hs));
        chk("pipe_pixel", 64'(bus.pipe_pixel), 64'(prev_pix));
        chk("err_sync", 64'(bus.err_sync), 64'(exp_err));
        chk("credit_sum", 64'(bus.dbg_inflight) + 64'(bus.dbg_cnt), 64'(outstanding));

        if (bus.req_valid == 2'b11) g = exp_last ? 2'b01 : 2'b10;
        else                        g = bus.req_valid;
        exp_rdy = (outstanding < FIFO_D) ? g : 2'b00;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        if ((bus.req_valid & bus.req_ready) != 2'b00) obs_hs++;
        if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        if (ev && bus.out_ready) begin
            void'(exp_q.pop_front());
            void'(exp_rdy_q.pop_front());
            outstanding--;
        end
        prev_hs = (exp_rdy != 2'b00);
        if (prev_hs) begin
            q = exp_rdy[1] ? bus.req_pixel1 : bus.req_pixel0;
            exp_q.push_back({exp_rdy[1], f_mag(q), f_tan(q)});
            exp_rdy_q.push_back(cyc + 2 + LAT);
            outstanding++;
            exp_last    = exp_rdy[1];
            prev_pix    = q;
            last_hs_cyc = cyc;
        end
        if (spur) exp_err = 1'b1;
    endtask

    // Inputs are set at the falling edge before each call.
    task automatic cycle();
        pipe_step();
        #1;
        model_step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        bus.req_valid = 2'b00;
        bus.out_ready = 1'b0;
        spur = 1'b0;
        repeat (n) cycle();
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_pipe_ivalid", 64'(bus.pipe_ivalid), 64'(0));
        chk("rst_pipe_pixel", 64'(bus.pipe_pixel), 64'(0));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_mag", 64'(bus.out_mag), 64'(0));
        chk("rst_out_tan", 64'(bus.out_tan), 64'(0));
        chk("rst_out_id", 64'(bus.out_id), 64'(0));
        chk("rst_err_sync", 64'(bus.err_sync), 64'(0));
        chk("rst_inflight", 64'(bus.dbg_inflight), 64'(0));
        chk("rst_cnt", 64'(bus.dbg_cnt), 64'(0));
        rst = 1'b1;
    endtask

    task automatic single_issue(input string tag);
        bus.req_valid  = 2'b01;
        bus.req_pixel0 = {8'd10, 8'd20, 8'd30, 8'd40};
        bus.out_ready  = 1'b1;
        first_valid_cyc = -1;
        cycle();
        bus.req_valid = 2'b00;
        repeat (25) cycle();
        chk(tag, 64'(first_valid_cyc - last_hs_cyc), 64'(2 + LAT));
    endtask

    initial begin
        int h0;
        int n;
        bus.req_valid   = 2'b00;
        bus.req_pixel0  = '0;
        bus.req_pixel1  = '0;
        bus.out_ready   = 1'b0;
        bus.pipe_ovalid = 1'b0;
        bus.pipe_mag    = '0;
        bus.pipe_tan    = '0;
        spur = 1'b0;
        obs_hs = 0;
        last_hs_cyc = 0;
        first_valid_cyc = -1;
        for (int i = 0; i <= LAT; i++) pline[i] = '0;
        @(negedge clk);
        do_reset(2);

        single_issue("single_latency");

        // Fairness: both requesters always valid, sink always ready.
        h0 = obs_hs;
        bus.req_valid = 2'b11;
        bus.out_ready = 1'b1;
        repeat (40) begin
            bus.req_pixel0 = $urandom;
            bus.req_pixel1 = $urandom;
            cycle();
        end
        chk("fair_no_gap", 64'(obs_hs - h0), 64'(40));
        bus.req_valid = 2'b00;
        repeat (25) cycle();

        // Full throttle with a stalled sink, then a single pop.
        h0 = obs_hs;
        bus.req_valid = 2'b11;
        bus.out_ready = 1'b0;
        repeat (60) begin
            bus.req_pixel0 = $urandom;
            bus.req_pixel1 = $urandom;
            cycle();
        end
        chk("throttle_count", 64'(obs_hs - h0), 64'(FIFO_D));
        chk("throttle_ready", 64'(bus.req_ready), 64'(0));
        h0 = obs_hs;
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        repeat (20) cycle();
        chk("reopen_count", 64'(obs_hs - h0), 64'(1));
        bus.req_valid = 2'b00;
        bus.out_ready = 1'b1;
        repeat (60) cycle();
        chk("throttle_drained", 64'(bus.dbg_cnt), 64'(0));

        // Random streaming over 1000 accepted quads.
        h0 = obs_hs;
        n = 0;
        while ((obs_hs - h0) < 1000 && n < 20000) begin
            bus.req_valid  = 2'($urandom_range(0, 3));
            bus.req_pixel0 = $urandom;
            bus.req_pixel1 = $urandom;
            bus.out_ready  = ($urandom_range(0, 9) != 0);
            cycle();
            n++;
        end
        chk("random_done", 64'((obs_hs - h0) >= 1000), 64'(1));
        bus.req_valid = 2'b00;
        bus.out_ready = 1'b1;
        repeat (60) cycle();
        chk("random_drained", 64'(bus.dbg_cnt), 64'(0));
        chk("random_idle", 64'(bus.dbg_inflight), 64'(0));

        // Spurious return with nothing in flight.
        spur = 1'b1;
        cycle();
        spur = 1'b0;
        repeat (3) cycle();
        chk("spur_err", 64'(bus.err_sync), 64'(1));
        chk("spur_empty", 64'(bus.out_valid), 64'(0));

        // Reset with ten quads in flight, then a clean single issue.
        bus.req_valid = 2'b01;
        bus.out_ready = 1'b1;
        repeat (10) begin
            bus.req_pixel0 = $urandom;
            cycle();
        end
        chk("midrst_inflight", 64'(bus.dbg_inflight), 64'(10));
        do_reset(1);
        single_issue("post_reset_latency");
        chk("post_reset_err", 64'(bus.err_sync), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mag_sched.md
# mag_sched

Issue scheduler and result buffer for the shared gradient-magnitude pipeline. It round-robin arbitrates 4-neighbour pixel quads from two requesters (even/odd cell-row engines) into the single fixed-latency, non-stallable magnitude/tan pipeline. It tags every issue with its requester id and buffers the returned magnitude/tan pairs in a result FIFO with valid/ready output. Credit accounting guarantees that a returning result always has a FIFO slot, so the pipeline never needs backpressure.

## Interface
- PIX_W, 8, pixel width; quad width is 4*PIX_W, packed {top, bot, left, right}
- MAG_W, 13, magnitude width from the pipeline
- TAN_W, 12, tan width from the pipeline
- LAT, 16, pipeline latency from pipe_ivalid to pipe_ovalid, in cycles
- FIFO_D, 32, result FIFO depth (power of 2, ≥ 2)

Ports (reset rst, synchronous, active-low; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- req_valid  in  2  per-requester quad valid
- req_ready  out  2  per-requester accept
- req_pixel0  in  4*PIX_W  requester 0 quad
- req_pixel1  in  4*PIX_W  requester 1 quad
- pipe_ivalid  out  1  issue strobe to pipeline
- pipe_pixel  out  4*PIX_W  issued quad
- pipe_ovalid  in  1  pipeline result valid
- pipe_mag  in  MAG_W  pipeline magnitude
- pipe_tan  in  TAN_W  pipeline tan
- out_valid  out  1  result available
- out_ready  in  1  downstream accept
- out_mag  out  MAG_W  head-of-FIFO magnitude
- out_tan  out  TAN_W  head-of-FIFO tan
- out_id  out  1  requester id of the head result
- err_sync  out  1  sticky: pipe_ovalid arrived with nothing in flight

## Operation
- Arbiter: round-robin with pointer `last`, reset 1, so requester 0 wins first. If both are valid, the requester ≠ last is granted. If only one is valid, that one is granted. `last` updates only on an accepted handshake.
- Credit: `inflight` counts quads accepted but not yet written to the FIFO. `cnt` is FIFO occupancy. credit_ok = (inflight + cnt) < FIFO_D, both widths log2(FIFO_D)+1.
- req_ready[g] = grant[g] & credit_ok; it is combinational and depends on req_valid. At most one bit is high. Handshake = req_valid[i] & req_ready[i].
- Issue stage is registered. The cycle after a handshake, pipe_ivalid=1 and pipe_pixel = granted quad. Otherwise pipe_ivalid=0 and pipe_pixel holds its last value.
- Tag path: a LAT+1-deep shift register carries {valid, id} from the handshake edge. Its tail aligns with pipe_ovalid.
- Return handling:
  - On pipe_ovalid=1 with inflight>0: write {tail id, pipe_mag, pipe_tan} into the FIFO.
  - On pipe_ovalid=1 with inflight==0: drop the data and set err_sync.
  - A mismatch between pipe_ovalid and the tail valid bit also sets err_sync; the data is still written if inflight>0.
- inflight: +1 on handshake, −1 on accepted return, unchanged when both happen in the same cycle.
- FIFO: first-word-fall-through. out_valid = (cnt != 0). Pop on out_valid & out_ready. Simultaneous write and pop leaves cnt unchanged. A write never overflows because credit guarantees a slot; overflow is unreachable by construction.
- Pointers wrap modulo FIFO_D.

## Timing
- Reset values:
  - req_ready=0 (while rst low)
  - pipe_ivalid=0, pipe_pixel=0
  - out_valid=0, out_mag=0, out_tan=0, out_id=0
  - err_sync=0
  - inflight=0, cnt=0, pointers=0, tag shift register cleared, last=1
- Reset mid-operation: all state is discarded in the same edge. The pipeline shares rst, so no stale returns are expected. Any stale return counts as an error.
- Throughput: one issue per cycle when credit allows; the FIFO accepts one write and one pop per cycle.
- Latency:
  - handshake at edge t → pipe_ivalid high after t+1
  - pipe_ovalid at t+1+LAT → FIFO write at that edge
  - out_valid high after t+2+LAT if the FIFO was empty
- Full throttle: with out_ready=0, exactly FIFO_D handshakes are accepted, then req_ready stays 0. A single pop re-opens exactly one credit in the next cycle.
- err_sync clears only on reset.

## Test plan
- Single issue: req_valid=01, quad {10,20,30,40}, out_ready=1 → pipe_ivalid 1 cycle after the handshake; pipe_pixel matches; out_valid 2+LAT=18 cycles after the handshake; out_id=0.
- Fairness: both requesters valid continuously, out_ready=1 → grants alternate 0,1,0,1…; out_id sequence alternates; no gap cycles on pipe_ivalid.
- Backpressure: out_ready=0, both requesters valid → exactly 32 handshakes, then req_ready=00. Raise out_ready for 1 cycle → exactly one more handshake. Results come out in issue order.
- Simultaneous push/pop: steady streaming with out_ready=1 → cnt stays constant, no loss, no duplicate; compare against a scoreboard over 1000 random quads.
- Spurious return: force pipe_ovalid=1 with nothing issued → err_sync=1 next cycle, FIFO stays empty.
- Reset mid-stream: assert rst low with 10 in flight → all outputs reach their reset values next cycle; after release, a new issue completes normally with 18-cycle latency.
